sm_run_ctrl: RTL



---
 rtl/sm_run_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run / halt / single-step controller for the single-cycle core.
// Produces the core clock-enable (gates PC and register-file write). A debug
// host can halt the core, step N instructions, or run to a PC breakpoint.
// Also counts retired instructions (every enabled cycle retires one).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmdRun/Halt/Step   debug commands, sampled at posedge (Halt > Step > Run)
//   stepCnt            instructions per step (0 treated as 1)
//   bpEn, bpAddr       PC breakpoint enable and address
//   pc                 current CPU PC (instruction-memory address)
//   cntClr             synchronous clear of instrCount
//   cpuEn              core clock-enable (combinational from state and pc)
//   halted, bpHit      state == HALT; last halt caused by the breakpoint
//   state              00 HALT, 01 RUN, 10 STEP
//   instrCount         enabled-cycle counter, wraps
module sm_run_ctrl #(
    parameter bit RESET_RUN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmdRun,
    input  logic        cmdHalt,
    input  logic        cmdStep,
    input  logic [15:0] stepCnt,
    input  logic        bpEn,
    input  logic [31:0] bpAddr,
    input  logic [31:0] pc,
    input  logic        cntClr,
    output logic        cpuEn,
    output logic        halted,
    output logic        bpHit,
    output logic [1:0]  state,
    output logic [31:0] instrCount
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    localparam state_e RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    state_e      state_q, state_d;
    logic [15:0] steps_left_q, steps_left_d;
    logic        skip_q, skip_d;
    logic        bp_hit_q, bp_hit_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic        bp_match;
    logic        cpu_en;
    logic [15:0] step_load;

    // skip masks the breakpoint for the first enabled cycle after a resume,
    // so the instruction sitting at bpAddr can execute once.
    assign bp_match  = bpEn & (pc == bpAddr) & ~skip_q;
    assign cpu_en    = ((state_q == ST_RUN) | (state_q == ST_STEP)) & ~bp_match;
    assign step_load = (stepCnt == 16'd0) ? 16'd1 : stepCnt;

    always_comb begin
        state_d       = state_q;
        steps_left_d  = steps_left_q;
        skip_d        = cpu_en ? 1'b0 : skip_q;
        bp_hit_d      = bp_hit_q;
        instr_count_d = instr_count_q;

        if (cntClr)      instr_count_d = 32'd0;
        else if (cpu_en) instr_count_d = instr_count_q + 32'd1;

        if (cmdHalt) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_HALT: begin
                    if (cmdStep) begin
                        state_d      = ST_STEP;
                        steps_left_d = step_load;
                        skip_d       = 1'b1;
                        bp_hit_d     = 1'b0;
                    end else if (cmdRun) begin
                        state_d  = ST_RUN;
                        skip_d   = 1'b1;
                        bp_hit_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bp_match) begin
                        state_d  = ST_HALT;
                        bp_hit_d = 1'b1;
                    end else if (cmdStep) begin
                        state_d      = ST_STEP;
                        steps_left_d = step_load;
                    end
                end
                ST_STEP: begin
                    if (bp_match) begin
                        state_d  = ST_HALT;
                        bp_hit_d = 1'b1;
                    end else if (cmdStep) begin
                        steps_left_d = step_load;
                    end else if (cmdRun) begin
                        state_d = ST_RUN;
                    end else if (cpu_en) begin
                        steps_left_d = steps_left_q - 16'd1;
                        if (steps_left_q == 16'd1) state_d = ST_HALT;
                    end
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_STATE;
            steps_left_q  <= 16'd0;
            skip_q        <= 1'b0;
            bp_hit_q      <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            steps_left_q  <= steps_left_d;
            skip_q        <= skip_d;
            bp_hit_q      <= bp_hit_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cpuEn      = cpu_en;
    assign halted     = (state_q == ST_HALT);
    assign bpHit      = bp_hit_q;
    assign state      = state_q;
    assign instrCount = instr_count_q;

endmodule
